// File: rtl/fmul_arbiter.sv
// fmul_arbiter: round-robin sharing of one fixed-latency pipelined fmul among NREQ requesters
//   sys_clk, rst                  : clock, synchronous active-high reset
//   req_valid/req_x1/req_x2       : per-requester operand pairs (32 bits per requester, packed)
//   req_ready                     : one-hot grant, combinational from req_valid and the rr pointer
//   resp_valid/resp_y/resp_ovf/unf: one-hot result steering back to the originating requester
//   fmul_*                        : issue to and results from the external fmul
//   err                           : sticky, fmul_out_valid disagreed with the tag pipe
module fmul_arbiter #(
  parameter int NREQ = 2,
  parameter int LAT = 3,
  parameter int IDW = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*32-1:0]  req_x1,
  input  logic [NREQ*32-1:0]  req_x2,
  output logic [NREQ-1:0]     req_ready,
  output logic [NREQ-1:0]     resp_valid,
  output logic [31:0]         resp_y,
  output logic                resp_ovf,
  output logic                resp_unf,
  output logic                fmul_valid,
  output logic [31:0]         fmul_x1,
  output logic [31:0]         fmul_x2,
  input  logic [31:0]         fmul_y,
  input  logic                fmul_ovf,
  input  logic                fmul_unf,
  input  logic                fmul_out_valid,
  output logic                err
);
  localparam int SW = $clog2(LAT + 1);
  logic [IDW-1:0] ptr, gidx, iss_tag;
  logic [NREQ-1:0] grant;
  logic [31:0] gx1, gx2, iss_x1, iss_x2;
  logic iss_v;
  logic [LAT-1:0] tag_v;
  logic [IDW-1:0] tag_id [LAT];
  logic [SW-1:0] settle;
  // Lowest index below ptr wins first, then the lowest index at or above ptr overrides it,
  // which is the first valid requester scanning ptr, ptr+1, ... mod NREQ.
  always_comb begin
    grant = '0;
    gidx = ptr;
    gx1 = '0;
    gx2 = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req_valid[i] && i < int'(ptr)) begin
        grant = '0;
        grant[i] = 1'b1;
        gidx = IDW'(i);
        gx1 = req_x1[32*i +: 32];
        gx2 = req_x2[32*i +: 32];
      end
    for (int i = NREQ - 1; i >= 0; i--)
      if (req_valid[i] && i >= int'(ptr)) begin
        grant = '0;
        grant[i] = 1'b1;
        gidx = IDW'(i);
        gx1 = req_x1[32*i +: 32];
        gx2 = req_x2[32*i +: 32];
      end
  end
  always_comb begin
    resp_valid = '0;
    resp_valid[tag_id[LAT-1]] = tag_v[LAT-1];
  end
  assign req_ready = grant;
  assign fmul_valid = iss_v;
  assign fmul_x1 = iss_x1;
  assign fmul_x2 = iss_x2;
  assign resp_y = fmul_y;
  assign resp_ovf = fmul_ovf;
  assign resp_unf = fmul_unf;
  // settle hides the fmul's unreset valid pipe for LAT cycles after reset
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      ptr <= '0;
      iss_v <= 1'b0;
      tag_v <= '0;
      err <= 1'b0;
      settle <= SW'(LAT);
    end else begin
      ptr <= |grant ? (gidx == IDW'(NREQ - 1) ? '0 : gidx + 1'b1) : ptr;
      iss_v <= |grant;
      tag_v <= (tag_v << 1) | LAT'(iss_v);
      settle <= settle - SW'(settle != '0);
      err <= err | (settle == '0 && fmul_out_valid != tag_v[LAT-1]);
    end
  end
  always_ff @(posedge sys_clk) begin
    if (|grant) begin
      iss_x1 <= gx1;
      iss_x2 <= gx2;
      iss_tag <= gidx;
    end
    tag_id[0] <= iss_tag;
    for (int k = 1; k < LAT; k++) tag_id[k] <= tag_id[k-1];
  end
endmodule

// File: tb/tb_fmul_arbiter.sv
// tb_fmul_arbiter: randomized scoreboard bench for fmul_arbiter with a behavioural fmul stand-in
module tb_fmul_arbiter;
  localparam int N = 3;
  localparam int L = 3;
  logic sys_clk = 1'b0;
  logic rst = 1'b1;
  logic inj = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N*32-1:0] req_x1 = '0, req_x2 = '0;
  logic [N-1:0] req_ready, resp_valid;
  logic [31:0] resp_y, fmul_x1, fmul_x2, fmul_y;
  logic resp_ovf, resp_unf, fmul_valid, fmul_ovf, fmul_unf, fmul_out_valid, err;

  always #5 sys_clk = ~sys_clk;

  fmul_arbiter #(.NREQ(N), .LAT(L)) dut (
    .sys_clk(sys_clk), .rst(rst), .req_valid(req_valid), .req_x1(req_x1), .req_x2(req_x2),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_y(resp_y), .resp_ovf(resp_ovf),
    .resp_unf(resp_unf), .fmul_valid(fmul_valid), .fmul_x1(fmul_x1), .fmul_x2(fmul_x2),
    .fmul_y(fmul_y), .fmul_ovf(fmul_ovf), .fmul_unf(fmul_unf),
    .fmul_out_valid(fmul_out_valid), .err(err)
  );

  // truncating single-precision multiply for normal operands, returns {ovf, unf, y}
  function automatic logic [33:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] m;
    logic [22:0] f;
    int e;
    m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (m[47]) begin
      e++;
      f = m[46:24];
    end else f = m[45:23];
    return {e >= 255, e <= 0, a[31] ^ b[31], e[7:0], f};
  endfunction

  // fmul stand-in: fixed latency, valid pipe deliberately not reset
  logic pvld [L];
  logic [33:0] pdat [L];
  always @(posedge sys_clk) begin
    pvld[0] <= fmul_valid;
    pdat[0] <= fmul_ref(fmul_x1, fmul_x2);
    for (int k = 1; k < L; k++) begin
      pvld[k] <= pvld[k-1];
      pdat[k] <= pdat[k-1];
    end
  end
  assign fmul_out_valid = pvld[L-1] | inj;
  assign {fmul_ovf, fmul_unf, fmul_y} = pdat[L-1];

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [N-1:0] who;
    logic [33:0] r;
    int due;
  } exp_t;
  exp_t sb[$];
  int cyc = 0, mp = 0, run = 0, max_run = 0;
  logic pv_m = 1'b0;
  logic [31:0] pa = '0, pb = '0, last_y = '0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // monitor + reference model, evaluated mid-cycle
  always @(negedge sys_clk) begin
    logic [N-1:0] eg;
    exp_t e;
    if (resp_valid != '0 || (sb.size() > 0 && sb[0].due <= cyc)) begin
      if (sb.size() == 0) chk("resp_spurious", 64'(resp_valid), 64'd0);
      else begin
        e = sb.pop_front();
        chk("resp_who", 64'(resp_valid), 64'(e.who));
        chk("resp_data", 64'({resp_ovf, resp_unf, resp_y}), 64'(e.r));
        chk("resp_cycle", 64'(cyc), 64'(e.due));
        last_y = resp_y;
      end
    end
    run = (resp_valid == 3'b010) ? run + 1 : 0;
    if (run > max_run) max_run = run;
    eg = '0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (mp + k) % N;
      if (eg == '0 && req_valid[j]) eg[j] = 1'b1;
    end
    chk("grant", 64'(req_ready), 64'(eg));
    chk("fmul_valid", 64'(fmul_valid), 64'(pv_m));
    if (pv_m) chk("fmul_ops", {fmul_x1, fmul_x2}, {pa, pb});
    if (rst) begin
      mp = 0;
      pv_m = 1'b0;
      sb.delete();
    end else begin
      pv_m = |eg;
      for (int j = 0; j < N; j++)
        if (eg[j]) begin
          pa = req_x1[32*j +: 32];
          pb = req_x2[32*j +: 32];
          mp = (j + 1) % N;
          sb.push_back('{eg, fmul_ref(pa, pb), cyc + 1 + L});
        end
    end
  end

  task automatic step(input logic [N-1:0] v, input logic [N*32-1:0] a, input logic [N*32-1:0] b);
    req_valid = v;
    req_x1 = a;
    req_x2 = b;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic rnd(input logic [N-1:0] v);
    logic [N*32-1:0] a, b;
    for (int i = 0; i < N; i++) begin
      a[32*i +: 32] = $urandom;
      b[32*i +: 32] = $urandom;
    end
    step(v, a, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0);
  endtask

  initial begin
    logic [N*32-1:0] a, b;
    repeat (2) @(posedge sys_clk);
    #1 rst = 1'b0;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_resp", 64'(resp_valid), 64'd0);
    chk("rst_fmul_valid", 64'(fmul_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    idle(2);
    a = '0;
    b = '0;
    a[31:0] = 32'h40000000;
    b[31:0] = 32'h40400000;
    step(3'b001, a, b);
    idle(6);
    chk("single_y", 64'(last_y), 64'h40C00000);
    chk("single_err", 64'(err), 64'd0);
    for (int i = 0; i < 3; i++) rnd(3'b101);
    idle(6);
    for (int i = 0; i < 4; i++) rnd(3'b011);
    idle(6);
    for (int k = 0; k < 10; k++) begin
      a = '0;
      b = '0;
      a[63:32] = 32'h3F800000;
      b[63:32] = 32'h3F800000 + (k << 23);
      step(3'b010, a, b);
    end
    idle(6);
    chk("stream_run", 64'(max_run), 64'd10);
    rnd(3'b001);
    rnd(3'b010);
    rnd(3'b100);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(2);
    rnd(3'b001);
    idle(6);
    chk("rst_flight_err", 64'(err), 64'd0);
    for (int i = 0; i < 300; i++) rnd(N'($urandom));
    idle(8);
    chk("drain", 64'(sb.size()), 64'd0);
    chk("err_before", 64'(err), 64'd0);
    inj = 1'b1;
    idle(1);
    inj = 1'b0;
    chk("err_set", 64'(err), 64'd1);
    idle(4);
    chk("err_sticky", 64'(err), 64'd1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("err_clear", 64'(err), 64'd0);
    inj = 1'b1;
    idle(1);
    inj = 1'b0;
    idle(1);
    chk("err_masked", 64'(err), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
